// File: rtl/chip8_sprite_drawer_pkg.sv
// chip8_sprite_drawer_pkg: framebuffer geometry and sprite drawer FSM states
package chip8_sprite_drawer_pkg;
  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int COL_W = $clog2(SCREEN_W);
  localparam int ROW_W = $clog2(SCREEN_H);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, MERGE, FINISH} state_t;
endpackage

// File: rtl/chip8_sprite_drawer_mask.sv
// chip8_sprite_drawer_mask: places a sprite byte at column x of a framebuffer row (rotate or clip)
module chip8_sprite_drawer_mask import chip8_sprite_drawer_pkg::*; #(
  parameter int WRAP = 1
) (
  input  logic [7:0]          data,
  input  logic [COL_W-1:0]    x,
  output logic [SCREEN_W-1:0] mask
);
  logic [SCREEN_W-1:0] line;
  logic [COL_W:0]      back;
  assign line = {data, {(SCREEN_W-8){1'b0}}};
  assign back = (COL_W+1)'(SCREEN_W) - {1'b0, x};
  // x=0 gives back=SCREEN_W, so the wrapped part shifts out to zero
  assign mask = (WRAP != 0) ? (line >> x) | (line << back) : line >> x;
endmodule

// File: rtl/chip8_sprite_drawer.sv
// chip8_sprite_drawer: DXYN sprite XOR draw and 00E0 clear over a row-wide framebuffer port
module chip8_sprite_drawer import chip8_sprite_drawer_pkg::*; #(
  parameter int WRAP = 1
) (
  input  logic                SYS_CLK,
  input  logic                RST,
  input  logic                draw_start,
  input  logic                clear_start,
  input  logic [7:0]          x_in,
  input  logic [7:0]          y_in,
  input  logic [3:0]          n_in,
  input  logic [11:0]         i_in,
  output logic [11:0]         mem_addr,
  output logic                mem_rd_en,
  input  logic [7:0]          mem_rdata,
  output logic [ROW_W-1:0]    fb_row,
  output logic                fb_rd_en,
  input  logic [SCREEN_W-1:0] fb_rdata,
  output logic                fb_wr_en,
  output logic [SCREEN_W-1:0] fb_wdata,
  output logic                busy,
  output logic                done,
  output logic                collision
);
  state_t              state;
  logic [3:0]          r, n_q, r_nx;
  logic [COL_W-1:0]    x_q;
  logic [ROW_W-1:0]    y_q;
  logic [11:0]         i_q, addr_nx;
  logic [ROW_W:0]      row_y;
  logic                more, on_screen, fetch_ok, hit;
  logic [SCREEN_W-1:0] mask;
  logic                unused_hi;
  assign unused_hi = ^{x_in[7:COL_W], y_in[7:ROW_W]};
  chip8_sprite_drawer_mask #(.WRAP(WRAP)) u_mask (
    .data(mem_rdata),
    .x   (x_q),
    .mask(mask)
  );
  // Next-row address/row is shared by the start of a draw and every row advance
  always_comb begin
    r_nx      = (state == IDLE) ? 4'd0 : r + 4'd1;
    row_y     = (ROW_W+1)'((state == IDLE) ? y_in[ROW_W-1:0] : y_q) + (ROW_W+1)'(r_nx);
    addr_nx   = ((state == IDLE) ? i_in : i_q) + 12'(r_nx);
    more      = (state == IDLE) ? (n_in != 4'd0) : (r_nx < n_q);
    on_screen = (WRAP != 0) || !row_y[ROW_W];
    fetch_ok  = more && on_screen;
    hit       = |(fb_rdata & mask);
    fb_wdata  = (state == MERGE) ? fb_rdata ^ mask : '0;
  end
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      r         <= '0;
      n_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      i_q       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      fb_row    <= '0;
      fb_rd_en  <= 1'b0;
      fb_wr_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      fb_rd_en  <= 1'b0;
      fb_wr_en  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state     <= CLEAR;
            fb_row    <= '0;
            fb_wr_en  <= 1'b1;
            busy      <= 1'b1;
            collision <= 1'b0;
          end else if (draw_start) begin
            x_q       <= x_in[COL_W-1:0];
            y_q       <= y_in[ROW_W-1:0];
            n_q       <= n_in;
            i_q       <= i_in;
            r         <= '0;
            collision <= 1'b0;
            if (fetch_ok) begin
              state     <= FETCH;
              busy      <= 1'b1;
              mem_rd_en <= 1'b1;
              fb_rd_en  <= 1'b1;
              mem_addr  <= addr_nx;
              fb_row    <= row_y[ROW_W-1:0];
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (&fb_row) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            fb_row   <= fb_row + 1'b1;
            fb_wr_en <= 1'b1;
          end
        end
        FETCH: begin
          state    <= MERGE;
          fb_wr_en <= 1'b1;
        end
        MERGE: begin
          collision <= collision | hit;
          if (fetch_ok) begin
            state     <= FETCH;
            r         <= r_nx;
            mem_rd_en <= 1'b1;
            fb_rd_en  <= 1'b1;
            mem_addr  <= addr_nx;
            fb_row    <= row_y[ROW_W-1:0];
          end else begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// tb_chip8_sprite_drawer: vector table plus corner sequences against memory/framebuffer models
module tb_chip8_sprite_drawer;
  logic        SYS_CLK = 1'b0, RST = 1'b1;
  logic        draw_start = 1'b0, clear_start = 1'b0;
  logic [7:0]  x_in = '0, y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_in = '0;
  logic [11:0] mem_addr, mem_addr_w0;
  logic        mem_rd_en, mem_rd_en_w0;
  logic [7:0]  mem_rdata = '0, mem_rdata_w0 = '0;
  logic [4:0]  fb_row, fb_row_w0;
  logic        fb_rd_en, fb_rd_en_w0, fb_wr_en, fb_wr_en_w0;
  logic [63:0] fb_rdata = '0, fb_rdata_w0 = '0, fb_wdata, fb_wdata_w0;
  logic        busy, busy_w0, done, done_w0, collision, collision_w0;

  always #5 SYS_CLK = ~SYS_CLK;

  chip8_sprite_drawer #(.WRAP(1)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .draw_start(draw_start), .clear_start(clear_start),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .fb_row(fb_row), .fb_rd_en(fb_rd_en), .fb_rdata(fb_rdata),
    .fb_wr_en(fb_wr_en), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .collision(collision));

  chip8_sprite_drawer #(.WRAP(0)) dut_w0 (
    .SYS_CLK(SYS_CLK), .RST(RST), .draw_start(draw_start), .clear_start(clear_start),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .mem_addr(mem_addr_w0), .mem_rd_en(mem_rd_en_w0), .mem_rdata(mem_rdata_w0),
    .fb_row(fb_row_w0), .fb_rd_en(fb_rd_en_w0), .fb_rdata(fb_rdata_w0),
    .fb_wr_en(fb_wr_en_w0), .fb_wdata(fb_wdata_w0),
    .busy(busy_w0), .done(done_w0), .collision(collision_w0));

  logic [7:0]  mem [4096];
  logic [63:0] fb [32];
  logic [63:0] fb0 [32];
  logic [11:0] addr_log [16];
  logic        fill = 1'b0, cnt_clr = 1'b0;
  logic [63:0] fill_val = '0;
  int          wr_cnt = 0, wr0_cnt = 0, strb_cnt = 0, rd_cnt = 0, n_log = 0, viol = 0;
  int          n_cmp = 0, n_bad = 0;

  always @(posedge SYS_CLK) begin
    if (fill) begin
      for (int k = 0; k < 32; k++) begin
        fb[k]  <= fill_val;
        fb0[k] <= fill_val;
      end
    end else begin
      if (fb_wr_en) fb[fb_row] <= fb_wdata;
      if (fb_wr_en_w0) fb0[fb_row_w0] <= fb_wdata_w0;
    end
    if (fb_rd_en) fb_rdata <= fb[fb_row];
    if (fb_rd_en_w0) fb_rdata_w0 <= fb0[fb_row_w0];
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_rd_en_w0) mem_rdata_w0 <= mem[mem_addr_w0];
    if (cnt_clr) begin
      wr_cnt <= 0; wr0_cnt <= 0; strb_cnt <= 0; rd_cnt <= 0; n_log <= 0;
    end else begin
      if (fb_wr_en) wr_cnt <= wr_cnt + 1;
      if (fb_wr_en_w0) wr0_cnt <= wr0_cnt + 1;
      strb_cnt <= strb_cnt + int'(mem_rd_en) + int'(fb_rd_en) + int'(fb_wr_en);
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (mem_rd_en && n_log < 16) begin
        addr_log[n_log] <= mem_addr;
        n_log <= n_log + 1;
      end
    end
    if ((fb_rd_en && fb_wr_en) || (fb_rd_en_w0 && fb_wr_en_w0)) viol <= viol + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic prep(input bit do_fill, input logic [63:0] v);
    fill_val = v;
    fill = do_fill;
    cnt_clr = 1'b1;
    @(posedge SYS_CLK); #1;
    fill = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Pulses the starts in cycle 0 and returns the cycle each DUT raised done (-1 on timeout)
  task automatic go(input bit clr, input bit drw, input logic [7:0] x, input logic [7:0] y,
                    input logic [3:0] n, input logic [11:0] i, input int pulse_at,
                    output int c1, output int c0);
    x_in = x; y_in = y; n_in = n; i_in = i;
    clear_start = clr; draw_start = drw;
    c1 = -1; c0 = -1;
    @(posedge SYS_CLK); #1;
    clear_start = 1'b0; draw_start = 1'b0;
    for (int k = 1; k < 100 && (c1 < 0 || c0 < 0); k++) begin
      if (k == pulse_at) begin
        draw_start = 1'b1; x_in = 8'd0; y_in = 8'd20; n_in = 4'd1; i_in = 12'h200;
      end else draw_start = 1'b0;
      if (done && c1 < 0) c1 = k;
      if (done_w0 && c0 < 0) c0 = k;
      @(posedge SYS_CLK); #1;
    end
    draw_start = 1'b0;
  endtask

  typedef struct {
    bit          wipe;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] i;
    int          cyc;
    bit          coll;
    logic [4:0]  ra;
    logic [63:0] va;
    logic [4:0]  rb;
    logic [63:0] vb;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int c1, c0, nz;
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
    mem[12'h100] = 8'hFF; mem[12'h101] = 8'hFF;
    mem[12'h200] = 8'hAA;
    mem[12'hFFF] = 8'h81;
    vecs[0] = '{1'b1, 8'd0,    8'd0,    4'd5, 12'h000, 11, 1'b0, 5'd1,  64'h9000_0000_0000_0000, 5'd4,  64'hF000_0000_0000_0000};
    vecs[1] = '{1'b0, 8'd0,    8'd0,    4'd5, 12'h000, 11, 1'b1, 5'd0,  64'h0,                   5'd3,  64'h0};
    vecs[2] = '{1'b1, 8'd62,   8'd31,   4'd2, 12'h100, 5,  1'b0, 5'd31, 64'hFC00_0000_0000_0003, 5'd0,  64'hFC00_0000_0000_0003};
    vecs[3] = '{1'b1, 8'h45,   8'h22,   4'd1, 12'h200, 3,  1'b0, 5'd2,  64'h0550_0000_0000_0000, 5'd3,  64'h0};
    vecs[4] = '{1'b1, 8'd0,    8'd10,   4'd2, 12'hFFF, 5,  1'b0, 5'd10, 64'h8100_0000_0000_0000, 5'd11, 64'hF000_0000_0000_0000};
    vecs[5] = '{1'b0, 8'd4,    8'd10,   4'd1, 12'h200, 3,  1'b0, 5'd10, 64'h8BA0_0000_0000_0000, 5'd11, 64'hF000_0000_0000_0000};
    vecs[6] = '{1'b0, 8'd0,    8'd10,   4'd1, 12'h004, 3,  1'b1, 5'd10, 64'h7BA0_0000_0000_0000, 5'd11, 64'hF000_0000_0000_0000};

    repeat (2) @(posedge SYS_CLK);
    #1;
    chk("reset_ctrl", 64'({mem_addr, mem_rd_en, fb_row, fb_rd_en, fb_wr_en, busy, done, collision}), 64'h0);
    chk("reset_wdata", fb_wdata, 64'h0);
    RST = 1'b0;
    @(posedge SYS_CLK); #1;

    for (int v = 0; v < 7; v++) begin
      prep(vecs[v].wipe, 64'h0);
      go(1'b0, 1'b1, vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].i, -1, c1, c0);
      chk($sformatf("vec%0d_done_cycle", v), 64'(c1), 64'(vecs[v].cyc));
      chk($sformatf("vec%0d_collision", v), 64'(collision), 64'(vecs[v].coll));
      chk($sformatf("vec%0d_row%0d", v, vecs[v].ra), fb[vecs[v].ra], vecs[v].va);
      chk($sformatf("vec%0d_row%0d", v, vecs[v].rb), fb[vecs[v].rb], vecs[v].vb);
    end

    // Clear from all-ones, following a draw that left collision set
    prep(1'b1, '1);
    go(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h0, -1, c1, c0);
    nz = 0;
    for (int k = 0; k < 32; k++) if (fb[k] != 64'h0) nz++;
    chk("clear_done_cycle", 64'(c1), 64'd33);
    chk("clear_collision", 64'(collision), 64'd0);
    chk("clear_writes", 64'(wr_cnt), 64'd32);
    chk("clear_nonzero_rows", 64'(nz), 64'd0);

    // Sprite address wraps past 0xFFF
    prep(1'b1, 64'h0);
    go(1'b0, 1'b1, 8'd0, 8'd10, 4'd2, 12'hFFF, -1, c1, c0);
    chk("addr_count", 64'(n_log), 64'd2);
    chk("addr_first", 64'(addr_log[0]), 64'hFFF);
    chk("addr_second", 64'(addr_log[1]), 64'h000);

    // Clipping variant at the bottom-right corner
    prep(1'b1, 64'h0);
    go(1'b0, 1'b1, 8'd62, 8'd31, 4'd2, 12'h100, -1, c1, c0);
    chk("clip_done_cycle", 64'(c0), 64'd3);
    chk("clip_row31", fb0[31], 64'h0000_0000_0000_0003);
    chk("clip_row0", fb0[0], 64'h0);
    chk("clip_writes", 64'(wr0_cnt), 64'd1);
    chk("wrap_done_cycle", 64'(c1), 64'd5);

    // n = 0 finishes at once with no bus activity
    prep(1'b1, 64'h0);
    go(1'b0, 1'b1, 8'd3, 8'd3, 4'd0, 12'h000, -1, c1, c0);
    chk("n0_done_cycle", 64'(c1), 64'd1);
    chk("n0_strobes", 64'(strb_cnt), 64'd0);
    chk("n0_collision", 64'(collision), 64'd0);

    // Clear and draw in the same cycle: clear only
    prep(1'b1, '1);
    go(1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h000, -1, c1, c0);
    chk("both_done_cycle", 64'(c1), 64'd33);
    chk("both_mem_reads", 64'(rd_cnt), 64'd0);
    chk("both_writes", 64'(wr_cnt), 64'd32);
    chk("both_row0", fb[0], 64'h0);

    // A draw_start while busy is ignored
    prep(1'b1, 64'h0);
    go(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h000, 3, c1, c0);
    chk("busy_done_cycle", 64'(c1), 64'd11);
    chk("busy_mem_reads", 64'(rd_cnt), 64'd5);
    chk("busy_row20", fb[20], 64'h0);
    chk("busy_row0", fb[0], 64'hF000_0000_0000_0000);

    // Reset during the MERGE of row 2 (cycle 6)
    prep(1'b1, 64'h0);
    x_in = 8'd0; y_in = 8'd0; n_in = 4'd5; i_in = 12'h000;
    draw_start = 1'b1;
    @(posedge SYS_CLK); #1;
    draw_start = 1'b0;
    repeat (5) @(posedge SYS_CLK);
    #1;
    chk("rst_merge_wr_en", 64'(fb_wr_en), 64'd1);
    chk("rst_merge_row", 64'(fb_row), 64'd2);
    RST = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'({mem_addr, mem_rd_en, fb_row, fb_rd_en, fb_wr_en, busy, done, collision}), 64'h0);
    chk("rst_mid_wdata", fb_wdata, 64'h0);
    repeat (2) @(posedge SYS_CLK);
    #1;
    RST = 1'b0;
    repeat (20) @(posedge SYS_CLK);
    #1;
    chk("rst_total_writes", 64'(wr_cnt), 64'd2);
    chk("rst_row1", fb[1], 64'h9000_0000_0000_0000);
    chk("rst_row2", fb[2], 64'h0);

    chk("rd_wr_same_cycle", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
